// File: rtl/path_read_buffer_pkg.sv
// Shared sizing helpers for the DRAM read-return path buffer.
package path_read_buffer_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned calc_depth(input int unsigned path_bursts,
                                             input int unsigned buffer_paths);
    return path_bursts * buffer_paths;
  endfunction

  // Counters must represent the full value Depth, hence Depth+1 states.
  function automatic int unsigned calc_cnt_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  function automatic int unsigned calc_idx_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/path_read_buffer_ram.sv
// Simple dual-port storage: synchronous write, registered read.
module path_read_buffer_ram #(
  parameter int unsigned Depth     = 128,
  parameter int unsigned Width     = 512,
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [Width-1:0]     i_wr_data,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [Width-1:0]     o_rd_data
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/path_read_buffer.sv
// DRAM read-return buffer: admits read commands only when space for the
// returning burst is reserved, and tags the last burst of every path.
module path_read_buffer
  import path_read_buffer_pkg::*;
#(
  parameter  int unsigned DDRDWidth   = 512,
  parameter  int unsigned PathBursts  = 64,
  parameter  int unsigned BufferPaths = 2,
  localparam int unsigned CntWidth    = calc_cnt_width(calc_depth(PathBursts, BufferPaths))
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_in_valid,
  input  logic                 i_cmd_in_read,
  output logic                 o_cmd_in_ready,
  output logic                 o_cmd_out_valid,
  input  logic                 i_cmd_out_ready,
  input  logic [DDRDWidth-1:0] i_in_data,
  input  logic                 i_in_valid,
  output logic [DDRDWidth-1:0] o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_out_last,
  input  logic                 i_flush,
  output logic [CntWidth-1:0]  o_occupancy,
  output logic [CntWidth-1:0]  o_outstanding,
  output logic                 o_overflow
);

  localparam int unsigned Depth      = calc_depth(PathBursts, BufferPaths);
  localparam int unsigned PtrWidth   = calc_idx_width(Depth);
  localparam int unsigned BurstWidth = calc_idx_width(PathBursts);

  logic [PtrWidth-1:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CntWidth-1:0]   r_occ, r_out, w_occ_nxt, w_out_nxt;
  logic [BurstWidth-1:0] r_burst, w_burst_nxt;
  logic                  r_out_valid, r_out_last, r_overflow;
  logic                  r_byp_sel;
  logic [DDRDWidth-1:0]  r_byp_data, w_ram_q;
  logic                  w_credit_ok, w_issue, w_pop, w_full, w_wr_en, w_drop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit admission and next-state accounting.
  always_comb begin
    w_full          = (r_occ == CntWidth'(Depth));
    w_credit_ok     = ((CntWidth+1)'(r_occ) + (CntWidth+1)'(r_out)) < (CntWidth+1)'(Depth);
    o_cmd_out_valid = i_cmd_in_valid & (~i_cmd_in_read | w_credit_ok);
    o_cmd_in_ready  = i_cmd_out_ready & (~i_cmd_in_read | w_credit_ok);
    w_issue         = i_cmd_in_valid & o_cmd_in_ready & i_cmd_in_read;
    w_pop           = r_out_valid & i_out_ready & ~i_flush;
    w_wr_en         = i_in_valid & (i_flush | ~w_full | w_pop);
    w_drop          = i_in_valid & ~w_wr_en;

    w_wr_ptr_nxt = w_wr_en ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (i_flush)    w_rd_ptr_nxt = r_wr_ptr;
    else if (w_pop) w_rd_ptr_nxt = ptr_inc(r_rd_ptr);

    if (i_flush) w_occ_nxt = CntWidth'(w_wr_en);
    else         w_occ_nxt = r_occ + CntWidth'(w_wr_en) - CntWidth'(w_pop);

    w_out_nxt = r_out + CntWidth'(w_issue) - CntWidth'(i_in_valid && (r_out != '0));

    w_burst_nxt = r_burst;
    if (i_flush)    w_burst_nxt = '0;
    else if (w_pop) w_burst_nxt = (r_burst == BurstWidth'(PathBursts - 1)) ? '0 : r_burst + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_out       <= '0;
      r_burst     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
      r_byp_sel   <= 1'b0;
      r_byp_data  <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_occ       <= w_occ_nxt;
      r_out       <= w_out_nxt;
      r_burst     <= w_burst_nxt;
      r_out_valid <= (w_occ_nxt != '0);
      r_out_last  <= (w_occ_nxt != '0) && (w_burst_nxt == BurstWidth'(PathBursts - 1));
      r_overflow  <= r_overflow | w_drop;
      // The registered RAM read misses a same-cycle write to the next head slot.
      r_byp_sel   <= w_wr_en && (r_wr_ptr == w_rd_ptr_nxt);
      if (w_wr_en) r_byp_data <= i_in_data;
    end
  end

  path_read_buffer_ram #(
    .Depth    (Depth),
    .Width    (DDRDWidth),
    .AddrWidth(PtrWidth)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(i_in_data),
    .i_rd_addr(w_rd_ptr_nxt),
    .o_rd_data(w_ram_q)
  );

  assign o_out_data    = r_byp_sel ? r_byp_data : w_ram_q;
  assign o_out_valid   = r_out_valid;
  assign o_out_last    = r_out_last;
  assign o_occupancy   = r_occ;
  assign o_outstanding = r_out;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_path_read_buffer.sv
// Directed bench for path_read_buffer with PathBursts=4, BufferPaths=2 (Depth=8).
module tb_path_read_buffer;

  localparam int unsigned W    = 32;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_in_valid, cmd_in_read, cmd_in_ready;
  logic            cmd_out_valid, cmd_out_ready;
  logic [W-1:0]    in_data, out_data;
  logic            in_valid, out_valid, out_ready, out_last, flush, overflow;
  logic [CntW-1:0] occupancy, outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  path_read_buffer #(.DDRDWidth(W), .PathBursts(4), .BufferPaths(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_in_valid (cmd_in_valid),
    .i_cmd_in_read  (cmd_in_read),
    .o_cmd_in_ready (cmd_in_ready),
    .o_cmd_out_valid(cmd_out_valid),
    .i_cmd_out_ready(cmd_out_ready),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .o_out_data     (out_data),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_last     (out_last),
    .i_flush        (flush),
    .o_occupancy    (occupancy),
    .o_outstanding  (outstanding),
    .o_overflow     (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_in_valid = 1'b0; cmd_in_read = 1'b0; cmd_out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic issue_reads(input int n);
    cmd_in_valid = 1'b1; cmd_in_read = 1'b1;
    for (int i = 0; i < n; i++) tick();
    cmd_in_valid = 1'b0; cmd_in_read = 1'b0;
  endtask

  task automatic returns(input int n, input logic [W-1:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + W'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pops(input int n, input logic [W-1:0] base, input int last_a, input int last_b);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("pop%0d_data", i), 64'(out_data), 64'(base + W'(i)));
      check($sformatf("pop%0d_last", i), 64'(out_last), 64'((i == last_a) || (i == last_b)));
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    #3 rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12 rst = 1'b0;
    #1;
    check("rst_occ",   64'(occupancy),   64'd0);
    check("rst_outst", 64'(outstanding), 64'd0);
    check("rst_ovf",   64'(overflow),    64'd0);
    check("rst_valid", 64'(out_valid),   64'd0);
    check("rst_last",  64'(out_last),    64'd0);
    check("rst_data",  64'(out_data),    64'd0);
    cmd_in_read = 1'b1;
    #1 check("rst_ready", 64'(cmd_in_ready), 64'd1);
    cmd_in_read = 1'b0;
    tick();

    // 1: exhaust credits with 8 reads
    issue_reads(8);
    check("t1_outst", 64'(outstanding), 64'd8);
    cmd_in_valid = 1'b1; cmd_in_read = 1'b1;
    #1;
    check("t1_rd_ready", 64'(cmd_in_ready),  64'd0);
    check("t1_rd_valid", 64'(cmd_out_valid), 64'd0);
    cmd_in_read = 1'b0;
    #1;
    check("t1_wr_ready", 64'(cmd_in_ready),  64'd1);
    check("t1_wr_valid", 64'(cmd_out_valid), 64'd1);
    cmd_in_valid = 1'b0;
    tick();

    // 2: return 8 bursts, OutValid the cycle after the first, then drain
    in_valid = 1'b1; in_data = 32'h100;
    tick();
    check("t2_valid_t1", 64'(out_valid), 64'd1);
    check("t2_data_t1",  64'(out_data),  64'h100);
    in_valid = 1'b0;
    returns(7, 32'h101);
    check("t2_occ",   64'(occupancy),   64'd8);
    check("t2_outst", 64'(outstanding), 64'd0);
    pops(8, 32'h100, 3, 7);
    check("t2_empty_valid", 64'(out_valid), 64'd0);
    check("t2_empty_occ",   64'(occupancy), 64'd0);

    // 3: overflow while full without a pop
    returns(8, 32'h200);
    returns(1, 32'hDEAD);
    check("t3_ovf",  64'(overflow),  64'd1);
    check("t3_occ",  64'(occupancy), 64'd8);
    check("t3_head", 64'(out_data),  64'h200);
    pops(8, 32'h200, 3, 7);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 4: issue, return and pop in the same cycle
    issue_reads(2);
    returns(1, 32'h300);
    check("t4_pre_occ",   64'(occupancy),   64'd1);
    check("t4_pre_outst", 64'(outstanding), 64'd1);
    cmd_in_valid = 1'b1; cmd_in_read = 1'b1;
    in_valid = 1'b1; in_data = 32'h301; out_ready = 1'b1;
    #1 check("t4_ready", 64'(cmd_in_ready), 64'd1);
    tick();
    idle_inputs();
    check("t4_occ",   64'(occupancy),   64'd1);
    check("t4_outst", 64'(outstanding), 64'd1);
    check("t4_head",  64'(out_data),    64'h301);

    do_reset();
    check("rst2_ovf", 64'(overflow), 64'd0);

    // 5: flush keeps outstanding accounting and restarts the burst count
    issue_reads(5);
    returns(3, 32'h400);
    check("t5_pre_occ", 64'(occupancy), 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_occ",   64'(occupancy),   64'd0);
    check("t5_outst", 64'(outstanding), 64'd2);
    check("t5_valid", 64'(out_valid),   64'd0);
    returns(4, 32'h500);
    check("t5_outst_after", 64'(outstanding), 64'd0);
    check("t5_occ_after",   64'(occupancy),   64'd4);
    pops(4, 32'h500, 3, 3);

    // 6: asynchronous reset mid-burst
    issue_reads(2);
    returns(1, 32'h600);
    in_valid = 1'b1; in_data = 32'h601;
    @(posedge clk);
    #2 rst = 1'b1;
    idle_inputs();
    cmd_in_read = 1'b1;
    #1;
    check("t6_occ",   64'(occupancy),    64'd0);
    check("t6_outst", 64'(outstanding),  64'd0);
    check("t6_valid", 64'(out_valid),    64'd0);
    check("t6_data",  64'(out_data),     64'd0);
    check("t6_ready", 64'(cmd_in_ready), 64'd1);
    #1 rst = 1'b0;
    cmd_in_read = 1'b0;
    tick();
    issue_reads(8);
    check("t6_credits", 64'(outstanding), 64'd8);
    cmd_in_read = 1'b1;
    #1 check("t6_no_credit", 64'(cmd_in_ready), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
